// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execute controller: widths, opcodes, flag
// bit positions, FSM encoding, the instruction payload and per-opcode helpers.
package alu_pkg;

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned ADDR_W   = 4;
  localparam int unsigned NUM_REGS = 16;
  localparam int unsigned OPC_W    = 5;
  localparam int unsigned FLAG_W   = 5;

  localparam logic [OPC_W-1:0] OP_ADD  = 5'd0;
  localparam logic [OPC_W-1:0] OP_SUB  = 5'd1;
  localparam logic [OPC_W-1:0] OP_CMP  = 5'd2;
  localparam logic [OPC_W-1:0] OP_AND  = 5'd3;
  localparam logic [OPC_W-1:0] OP_OR   = 5'd4;
  localparam logic [OPC_W-1:0] OP_XOR  = 5'd5;
  localparam logic [OPC_W-1:0] OP_NOT  = 5'd6;
  localparam logic [OPC_W-1:0] OP_LSH  = 5'd7;
  localparam logic [OPC_W-1:0] OP_RSH  = 5'd8;
  localparam logic [OPC_W-1:0] OP_ARSH = 5'd9;

  localparam int unsigned FLAG_C = 0;
  localparam int unsigned FLAG_L = 1;
  localparam int unsigned FLAG_F = 2;
  localparam int unsigned FLAG_Z = 3;
  localparam int unsigned FLAG_N = 4;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_OPERAND   = 2'd1,
    ST_EXECUTE   = 2'd2,
    ST_WRITEBACK = 2'd3
  } state_t;

  // Decoded instruction as captured at the accept edge.
  typedef struct packed {
    logic [OPC_W-1:0]  opcode;
    logic [ADDR_W-1:0] rdest;
    logic [ADDR_W-1:0] rsrc;
    logic [DATA_W-1:0] imm;
    logic              use_imm;
  } instr_t;

  // PSR bits an opcode is allowed to change; anything else keeps its value,
  // which also keeps undriven ALU flag bits out of the PSR.
  function automatic logic [FLAG_W-1:0] psr_mask(input logic [OPC_W-1:0] op);
    logic [FLAG_W-1:0] m;
    m = '0;
    case (op)
      OP_ADD, OP_SUB: begin
        m[FLAG_C] = 1'b1;
        m[FLAG_F] = 1'b1;
      end
      OP_CMP: begin
        m[FLAG_L] = 1'b1;
        m[FLAG_Z] = 1'b1;
        m[FLAG_N] = 1'b1;
      end
      default: m = '0;
    endcase
    return m;
  endfunction

  // Every defined opcode except CMP writes its result back.
  function automatic logic writes_result(input logic [OPC_W-1:0] op);
    return (op <= OP_ARSH) && (op != OP_CMP);
  endfunction

endpackage

// File: rtl/reg_file_2r1w.sv
// General register file: NUM_REGS x DATA_W, async clear, two combinational
// read ports, one combinational debug read port, one synchronous write port.
//   rd_addr_a/rd_data_a, rd_addr_b/rd_data_b : operand reads
//   dbg_addr/dbg_data                        : debug read
//   we/wr_addr/wr_data                       : write on rising clk when we=1
module reg_file_2r1w
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  logic [DATA_W-1:0] regs [NUM_REGS];

  // Storage with async clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(NUM_REGS); i++) regs[i] <= '0;
    end else if (we) begin
      regs[wr_addr] <= wr_data;
    end
  end

  assign rd_data_a = regs[rd_addr_a];
  assign rd_data_b = regs[rd_addr_b];
  assign dbg_data  = regs[dbg_addr];

endmodule

// File: rtl/alu_exec_ctrl.sv
// Execute controller around an external 16-bit ALU. Accepts one decoded
// instruction every 4 cycles, fetches operands from the register file, holds
// them on the ALU inputs for one cycle, then writes the result and updates
// the PSR selectively by opcode.
//   in_*      : instruction handshake (accepted when in_valid && in_ready)
//   alu_*     : ALU operand/opcode outputs, ALU result/flag inputs
//   psr       : status register {N,Z,F,L,C}
//   done      : one-cycle retire pulse
//   dbg_*     : combinational register file peek
module alu_exec_ctrl
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OPC_W-1:0]  in_opcode,
  input  logic [ADDR_W-1:0] in_rdest,
  input  logic [ADDR_W-1:0] in_rsrc,
  input  logic [DATA_W-1:0] in_imm,
  input  logic              in_use_imm,
  output logic [DATA_W-1:0] alu_rsrc,
  output logic [DATA_W-1:0] alu_rdest,
  output logic [OPC_W-1:0]  alu_opcode,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [FLAG_W-1:0] alu_flags,
  output logic [FLAG_W-1:0] psr,
  output logic              done,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  state_t            state_q, state_d;
  instr_t            ins_q;
  logic [DATA_W-1:0] res_q;
  logic [FLAG_W-1:0] flg_q;
  logic [DATA_W-1:0] rd_data_a, rd_data_b;
  logic              capture, operand_ld, exec_ld, wb_en;
  logic              ready_d, done_d;
  logic              rf_we;

  reg_file_2r1w u_rf (
    .clk       (clk),
    .reset_n   (reset_n),
    .rd_addr_a (ins_q.rdest),
    .rd_data_a (rd_data_a),
    .rd_addr_b (ins_q.rsrc),
    .rd_data_b (rd_data_b),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data),
    .we        (rf_we),
    .wr_addr   (ins_q.rdest),
    .wr_data   (res_q)
  );

  // Next-state and per-state strobes.
  always_comb begin
    state_d    = state_q;
    capture    = 1'b0;
    operand_ld = 1'b0;
    exec_ld    = 1'b0;
    wb_en      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          capture = 1'b1;
          state_d = ST_OPERAND;
        end
      end
      ST_OPERAND: begin
        operand_ld = 1'b1;
        state_d    = ST_EXECUTE;
      end
      ST_EXECUTE: begin
        exec_ld = 1'b1;
        state_d = ST_WRITEBACK;
      end
      ST_WRITEBACK: begin
        wb_en   = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // ready/done are registered, so decode them from the upcoming state.
    ready_d = (state_d == ST_IDLE);
    done_d  = (state_d == ST_WRITEBACK);
  end

  // State and handshake registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      in_ready <= 1'b1;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      in_ready <= ready_d;
      done     <= done_d;
    end
  end

  assign rf_we = wb_en && writes_result(ins_q.opcode);

  // Datapath: capture, operand fetch straight onto the ALU ports, result
  // latch, and masked PSR update.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ins_q      <= '0;
      alu_rdest  <= '0;
      alu_rsrc   <= '0;
      alu_opcode <= '0;
      res_q      <= '0;
      flg_q      <= '0;
      psr        <= '0;
    end else begin
      if (capture) begin
        ins_q <= '{opcode: in_opcode, rdest: in_rdest, rsrc: in_rsrc,
                   imm: in_imm, use_imm: in_use_imm};
      end
      if (operand_ld) begin
        alu_rdest  <= rd_data_a;
        alu_rsrc   <= ins_q.use_imm ? ins_q.imm : rd_data_b;
        alu_opcode <= ins_q.opcode;
      end
      if (exec_ld) begin
        res_q <= alu_out;
        flg_q <= alu_flags;
      end
      if (wb_en) begin
        psr <= (psr & ~psr_mask(ins_q.opcode)) | (flg_q & psr_mask(ins_q.opcode));
      end
    end
  end

endmodule
